// File: rtl/ans_ht_ltf_replay.sv
// ans_ht_ltf_replay
//   Buffers one HT-LTF time-domain symbol from an external combinational ROM,
//   waits an emulated compute latency, then on request replays the symbol
//   num_ltf times on an AXI-Stream style output, each repetition preceded by
//   its cyclic prefix (the last CP_LEN samples of the symbol).
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle burst request (accepted only in IDLE)
//   num_ltf    in   repetition count, sampled with start (1..MAX_REP)
//   abort      in   synchronous cancel of any burst
//   rom_addr   out  symbol ROM address during LOAD, zero otherwise
//   rom_data   in   ROM sample for rom_addr, same cycle
//   ready_out  out  symbol buffered and latency elapsed, awaiting go
//   go         in   level request to start streaming (READY only)
//   o_tdata    out  output sample, zero when o_tvalid is low
//   o_tvalid   out  output valid
//   o_tready   in   downstream ready
//   o_tlast    out  final sample of the final repetition
//   busy       out  high in every state except IDLE
//   err        out  one-cycle pulse on a rejected start
module ans_ht_ltf_replay #(
    parameter int DW       = 32,
    parameter int SYM_LEN  = 64,
    parameter int CP_LEN   = 16,
    parameter int MAX_REP  = 4,
    parameter int WAIT_CYC = 300
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 num_ltf,
    input  logic                       abort,
    output logic [$clog2(SYM_LEN)-1:0] rom_addr,
    input  logic [DW-1:0]              rom_data,
    output logic                       ready_out,
    input  logic                       go,
    output logic [DW-1:0]              o_tdata,
    output logic                       o_tvalid,
    input  logic                       o_tready,
    output logic                       o_tlast,
    output logic                       busy,
    output logic                       err
);

    localparam int AW = $clog2(SYM_LEN);
    localparam int WW = $clog2(WAIT_CYC) + 1;
    localparam logic [AW-1:0] CP_START = AW'(SYM_LEN - CP_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(SYM_LEN - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_READY,
        S_CP,
        S_BODY
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   load_q, load_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [2:0]      rep_q, rep_d;
    logic [2:0]      num_q, num_d;
    logic            ready_q, ready_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [DW-1:0]   buf_q [SYM_LEN];

    logic beat;
    logic start_ok;
    logic [2:0] rep_inc;

    assign beat     = tvalid_q & o_tready;
    assign start_ok = (num_ltf != 3'd0) && (32'(num_ltf) <= 32'(MAX_REP));
    assign rep_inc  = rep_q + 3'd1;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            load_q   <= '0;
            wait_q   <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            num_q    <= '0;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            num_q    <= num_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Symbol buffer; no reset, contents persist until the next LOAD
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            buf_q[load_q] <= rom_data;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        num_d   = num_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            load_d  = '0;
            wait_d  = '0;
            idx_d   = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort && start_ok) begin
                        state_d = S_LOAD;
                        num_d   = num_ltf;
                        load_d  = '0;
                        wait_d  = '0;
                        idx_d   = '0;
                        rep_d   = '0;
                    end
                end
                S_LOAD: begin
                    // load counter wraps back to zero as LOAD ends
                    load_d = load_q + 1'b1;
                    if (load_q == LAST_IDX) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_END) begin
                        state_d = S_READY;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (go) begin
                        state_d = S_CP;
                        idx_d   = CP_START;
                    end
                end
                S_CP: begin
                    // CP indices run to SYM_LEN-1 and wrap to 0 for BODY
                    if (beat) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (beat) begin
                        if (idx_q == LAST_IDX) begin
                            if (rep_inc < num_q) begin
                                state_d = S_CP;
                                idx_d   = CP_START;
                                rep_d   = rep_inc;
                            end else begin
                                state_d = S_IDLE;
                                idx_d   = '0;
                                rep_d   = '0;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Registered output next values, derived from the upcoming state
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        ready_d  = (state_d == S_READY);
        tvalid_d = (state_d == S_CP) || (state_d == S_BODY);
        tlast_d  = (state_d == S_BODY) && (idx_d == LAST_IDX) &&
                   (rep_d == (num_d - 3'd1));
        err_d    = (state_q == S_IDLE) && start && !abort && !start_ok;
    end

    assign rom_addr  = load_q;
    assign o_tdata   = tvalid_q ? buf_q[idx_q] : '0;
    assign o_tvalid  = tvalid_q;
    assign o_tlast   = tlast_q;
    assign ready_out = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ans_ht_ltf_replay.sv
module tb_ans_ht_ltf_replay;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    num_ltf = 3'd0;
    logic          abort = 1'b0;
    logic          go = 1'b0;
    logic          o_tready = 1'b0;
    logic [5:0]    rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rom_off = '0;
    logic [DW-1:0] o_tdata;
    logic          ready_out, o_tvalid, o_tlast, busy, err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // ROM[i] = i + rom_off
    assign rom_data = {26'b0, rom_addr} + rom_off;

    always #5 clk = ~clk;

    ans_ht_ltf_replay #(
        .DW(DW), .SYM_LEN(64), .CP_LEN(16), .MAX_REP(4), .WAIT_CYC(300)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_ltf(num_ltf),
        .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data),
        .ready_out(ready_out), .go(go), .o_tdata(o_tdata),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
        .busy(busy), .err(err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sample of beat b: [48..63, 0..63] per repetition, plus ROM offset
    function automatic logic [DW-1:0] exp_data(input int b, input logic [DW-1:0] off);
        int p;
        p = b % 80;
        return ((p < 16) ? 32'(48 + p) : 32'(p - 16)) + off;
    endfunction

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({ready_out, o_tvalid, o_tlast, busy, err} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {ready_out, o_tvalid, o_tlast, busy, err});
        else pass_cnt++;
        total_cnt++;
        if (o_tdata !== '0) $display("FAIL reset_tdata: got %h expected 0", o_tdata);
        else pass_cnt++;
        total_cnt++;
        if (rom_addr !== 6'd0) $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr);
        else pass_cnt++;
        tick();
        reset = 1'b0;
    endtask

    // Start a burst, check the LOAD address sweep and READY timing; ends in READY
    task automatic test_load_wait(input int n, input logic [DW-1:0] off);
        rom_off = off;
        start = 1'b1;
        num_ltf = 3'(n);
        tick();                       // edge E
        start = 1'b0;
        num_ltf = 3'd0;
        total_cnt++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL load_busy: got busy=%b err=%b expected busy=1 err=0", busy, err);
        else pass_cnt++;
        for (int i = 0; i < 64; i++) begin
            total_cnt++;
            if (rom_addr !== 6'(i)) $display("FAIL load_addr: got %0d expected %0d", rom_addr, i);
            else pass_cnt++;
            tick();
        end                           // after edge E+64, in WAIT
        total_cnt++;
        if (rom_addr !== 6'd0 || ready_out !== 1'b0) $display("FAIL wait_entry: got addr=%0d ready=%b expected 0 0", rom_addr, ready_out);
        else pass_cnt++;
        start = 1'b1;
        go = 1'b1;
        tick();                       // E+65: start and go ignored
        start = 1'b0;
        go = 1'b0;
        total_cnt++;
        if (err !== 1'b0 || ready_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL wait_ignore: got err=%b ready=%b busy=%b expected 0 0 1", err, ready_out, busy);
        else pass_cnt++;
        repeat (298) tick();          // E+363
        total_cnt++;
        if (ready_out !== 1'b0) $display("FAIL ready_early: got %b expected 0", ready_out);
        else pass_cnt++;
        tick();                       // E+364
        total_cnt++;
        if (ready_out !== 1'b1) $display("FAIL ready_late: got %b expected 1", ready_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ready_out !== 1'b1 || o_tvalid !== 1'b0) $display("FAIL ready_hold: got ready=%b valid=%b expected 1 0", ready_out, o_tvalid);
        else pass_cnt++;
    endtask

    // From READY: issue go and stream n repetitions, optionally toggling o_tready
    task automatic test_stream(input int n, input bit toggle, input logic [DW-1:0] off);
        int nb;
        int beats;
        int cyc;
        logic exp_last;
        nb = n * 80;
        beats = 0;
        cyc = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        total_cnt++;
        if (ready_out !== 1'b0 || o_tvalid !== 1'b1) $display("FAIL go_accept: got ready=%b valid=%b expected 0 1", ready_out, o_tvalid);
        else pass_cnt++;
        while (beats < nb && cyc < 4 * nb + 20) begin
            o_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            exp_last = (beats == nb - 1);
            total_cnt++;
            if (o_tvalid !== 1'b1 || o_tdata !== exp_data(beats, off) || o_tlast !== exp_last)
                $display("FAIL stream_beat%0d: got valid=%b data=%h last=%b expected 1 %h %b",
                         beats, o_tvalid, o_tdata, o_tlast, exp_data(beats, off), exp_last);
            else pass_cnt++;
            tick();
            if (o_tready) beats++;
            cyc++;
        end
        o_tready = 1'b0;
        total_cnt++;
        if (beats !== nb) $display("FAIL stream_len: got %0d beats expected %0d", beats, nb);
        else pass_cnt++;
        total_cnt++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== '0)
            $display("FAIL stream_end: got valid=%b busy=%b last=%b data=%h expected 0 0 0 0", o_tvalid, busy, o_tlast, o_tdata);
        else pass_cnt++;
    endtask

    task automatic test_err();
        logic [2:0] bad [2];
        bad[0] = 3'd0;
        bad[1] = 3'd5;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            num_ltf = bad[k];
            tick();
            start = 1'b0;
            num_ltf = 3'd0;
            total_cnt++;
            if (err !== 1'b1 || busy !== 1'b0 || rom_addr !== 6'd0)
                $display("FAIL err_pulse n=%0d: got err=%b busy=%b addr=%0d expected 1 0 0", bad[k], err, busy, rom_addr);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (err !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd0)
                $display("FAIL err_clear n=%0d: got err=%b busy=%b addr=%0d expected 0 0 0", bad[k], err, busy, rom_addr);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        test_load_wait(2, 32'h100);
        go = 1'b1;
        tick();
        go = 1'b0;
        o_tready = 1'b1;
        repeat (30) tick();
        total_cnt++;
        if (o_tvalid !== 1'b1 || o_tdata !== exp_data(30, 32'h100))
            $display("FAIL abort_pre: got valid=%b data=%h expected 1 %h", o_tvalid, o_tdata, exp_data(30, 32'h100));
        else pass_cnt++;
        abort = 1'b1;
        start = 1'b1;
        num_ltf = 3'd1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        num_ltf = 3'd0;
        o_tready = 1'b0;
        total_cnt++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || ready_out !== 1'b0 || o_tdata !== '0 || err !== 1'b0)
            $display("FAIL abort_idle: got valid=%b busy=%b ready=%b data=%h err=%b expected 0 0 0 0 0",
                     o_tvalid, busy, ready_out, o_tdata, err);
        else pass_cnt++;
        test_load_wait(1, 32'h200);
        test_stream(1, 1'b0, 32'h200);
    endtask

    task automatic check_reset_zero(input string tag);
        total_cnt++;
        if ({ready_out, o_tvalid, o_tlast, busy, err} !== 5'b0 || o_tdata !== '0 || rom_addr !== 6'd0)
            $display("FAIL %s: got flags=%b data=%h addr=%0d expected 00000 0 0",
                     tag, {ready_out, o_tvalid, o_tlast, busy, err}, o_tdata, rom_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rom_off = '0;
        start = 1'b1;
        num_ltf = 3'd1;
        tick();
        start = 1'b0;
        num_ltf = 3'd0;
        repeat (164) tick();          // inside WAIT
        #2 reset = 1'b1;
        #1 check_reset_zero("reset_mid_wait");
        tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || ready_out !== 1'b0) $display("FAIL reset_wait_after: got busy=%b ready=%b expected 0 0", busy, ready_out);
        else pass_cnt++;

        test_load_wait(1, '0);
        go = 1'b1;
        tick();
        go = 1'b0;
        o_tready = 1'b1;
        repeat (40) tick();           // inside BODY
        #2 reset = 1'b1;
        #1 check_reset_zero("reset_mid_body");
        tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_body_after: got valid=%b busy=%b expected 0 0", o_tvalid, busy);
        else pass_cnt++;
        o_tready = 1'b0;
        test_load_wait(1, '0);
        test_stream(1, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_load_wait(1, '0);
        test_stream(1, 1'b0, '0);
        test_err();
        test_load_wait(4, 32'h40);
        test_stream(4, 1'b1, 32'h40);
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ans_ht_ltf_replay.md
ANS_HT_LTF_REPLAY -- requirements
Module: ans_ht_ltf_replay

Interface
REQ-001 Parameter DW, default 32: sample width (I/Q packed).
REQ-002 Parameter SYM_LEN, default 64: time-domain symbol length in samples; power of two; minimum 16.
REQ-003 Parameter CP_LEN, default 16: cyclic prefix length; must be less than SYM_LEN.
REQ-004 Parameter MAX_REP, default 4: maximum HT-LTF repetitions per burst.
REQ-005 Parameter WAIT_CYC, default 300: emulated compute latency in cycles; minimum 1.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a burst.
REQ-009 num_ltf  in  3  repetition count; sampled with start.
REQ-010 abort  in  1  synchronous cancel of any burst.
REQ-011 rom_addr  out  log2(SYM_LEN)  address to external combinational symbol ROM.
REQ-012 rom_data  in  DW  ROM sample for rom_addr, valid in the same cycle.
REQ-013 ready_out  out  1  symbol buffered, compute wait done, awaiting go.
REQ-014 go  in  1  level request to start streaming.
REQ-015 o_tdata  out  DW  output sample.
REQ-016 o_tvalid  out  1  o_tdata valid.
REQ-017 o_tready  in  1  downstream accepts sample.
REQ-018 o_tlast  out  1  marks final sample of burst.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 err  out  1  one-cycle pulse on rejected start.

Function
REQ-021 States: IDLE, LOAD, WAIT, READY, CP, BODY; a beat is a cycle with o_tvalid and o_tready both high.
REQ-022 IDLE: start with 1 <= num_ltf <= MAX_REP latches num_ltf, clears counters and moves to LOAD; otherwise start pulses err next cycle and stays IDLE.
REQ-023 start outside IDLE is ignored; no err, no effect.
REQ-024 LOAD: rom_addr counts 0..SYM_LEN-1, one per cycle; rom_data is written into an internal SYM_LEN x DW buffer at rom_addr each cycle.
REQ-025 LOAD lasts exactly SYM_LEN cycles, then moves to WAIT.
REQ-026 WAIT lasts exactly WAIT_CYC cycles, then moves to READY; ready_out is registered high in the same transition.
REQ-027 READY: ready_out stays high until go is sampled high, then moves to CP; ready_out drops on that edge.
REQ-028 go outside READY is ignored.
REQ-029 CP: o_tvalid is high and o_tdata = buf[SYM_LEN-CP_LEN+k], k = 0..CP_LEN-1.
REQ-030 CP: k advances only on a beat; after beat CP_LEN-1, moves to BODY.
REQ-031 BODY: o_tvalid is high and o_tdata = buf[j], j = 0..SYM_LEN-1.
REQ-032 BODY: j advances only on a beat.
REQ-033 BODY: after beat SYM_LEN-1, the repetition counter increments; if it is below the latched num_ltf, moves to CP, otherwise to IDLE.
REQ-034 Burst length = num_ltf*(CP_LEN+SYM_LEN) beats, with no idle gap between repetitions when o_tready is held high.
REQ-035 o_tlast is high only on the final sample of the final repetition.
REQ-036 With o_tready low, o_tdata, o_tvalid and o_tlast hold stable.
REQ-037 o_tvalid is never deasserted without a beat, except on abort or reset.
REQ-038 o_tvalid is low in IDLE, LOAD, WAIT and READY; o_tdata is zero whenever o_tvalid is low.
REQ-039 abort in any non-IDLE state returns to IDLE on the next edge and clears ready_out, o_tvalid and the counters.
REQ-040 abort has priority over go, over beats and over simultaneous start.
REQ-041 Buffer contents persist in IDLE and are overwritten only by the next LOAD.
REQ-042 All outputs are registered except rom_addr and o_tdata; these are driven from registered counters.

Reset
REQ-043 On reset assertion, outputs go immediately and asynchronously to: ready_out=0, o_tvalid=0, o_tlast=0, busy=0, err=0, o_tdata=0, rom_addr=0.
REQ-044 On reset assertion, state=IDLE and all counters and the latched count are zero.
REQ-045 Buffer contents are undefined after reset.
REQ-046 Reset mid-burst terminates the burst with no further beats.
REQ-047 The first start is accepted on the first rising edge after reset deasserts.

Verification
REQ-048 Defaults, ROM[i]=i, num_ltf=1, start at edge E -> rom_addr 0..63 over edges E+1..E+64; ready_out high after edge E+364.
REQ-049 Same setup, go=1, o_tready=1 -> 80 consecutive beats; data 48..63 then 0..63; o_tlast only on beat 80 (data 63); busy low afterwards.
REQ-050 num_ltf=4, o_tready toggling 1/0 -> 320 beats in sequence [48..63,0..63]x4; data stable while stalled; single o_tlast.
REQ-051 num_ltf=0 and num_ltf=5 -> err pulse one cycle, busy stays 0, rom_addr stays 0.
REQ-052 abort at beat 30 of num_ltf=2 -> o_tvalid low next edge, state IDLE; a following start reloads and streams correctly.
REQ-053 Reset asserted mid-WAIT and mid-BODY -> all outputs zero immediately; start after release behaves as REQ-048.
